// File: rtl/mem_burst_arbiter_if.sv
// Requester, memory-port and status signals shared between the burst arbiter
// and its environment; slave is the arbiter side, master is everything else.
interface mem_burst_arbiter_if #(
  parameter int N     = 8,
  parameter int B     = 8,
  parameter int LEN_W = 4
);
  logic             req0, req1;
  logic             we0, we1;
  logic [N-1:0]     addr0, addr1;
  logic [LEN_W-1:0] len0, len1;
  logic [4*B-1:0]   wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             beat0, beat1;
  logic             last0, last1;
  logic             rvalid0, rvalid1;
  logic [4*B-1:0]   rdata0, rdata1;
  logic [N-1:0]     m_r_addr;
  logic [4*B-1:0]   m_r_data;
  logic [N-1:0]     m_w_addr;
  logic [4*B-1:0]   m_w_data;
  logic             m_write_en;
  logic             busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    input  m_r_data,
    output gnt0, gnt1, beat0, beat1, last0, last1,
    output rvalid0, rvalid1, rdata0, rdata1,
    output m_r_addr, m_w_addr, m_w_data, m_write_en, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    output m_r_data,
    input  gnt0, gnt1, beat0, beat1, last0, last1,
    input  rvalid0, rvalid1, rdata0, rdata1,
    input  m_r_addr, m_w_addr, m_w_data, m_write_en, busy
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Round-robin two-requester arbiter that sequences word bursts onto the data
// memory write port and second read port, one beat per cycle.
module mem_burst_arbiter #(
  parameter int N     = 8,
  parameter int B     = 8,
  parameter int LEN_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_burst_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_next;
  logic             owner;
  logic             op_we;
  logic             rr_last;
  logic [N-1:0]     cur_addr;
  logic [LEN_W-1:0] remaining;
  logic [4*B-1:0]   rdata0_q, rdata1_q;
  logic             rvalid0_q, rvalid1_q;

  logic             accept;
  logic             winner;
  logic             beat;
  logic             last;

  // Arbitration in IDLE and beat qualification in BURST; under contention the
  // requester that did not win last time is chosen.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    winner     = 1'b0;
    beat       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          accept     = 1'b1;
          winner     = (bus.req0 && bus.req1) ? ~rr_last : bus.req1;
          state_next = BURST;
        end
      end
      BURST: begin
        beat = 1'b1;
        last = (remaining == '0);
        if (last) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      op_we     <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      rr_last   <= 1'b1;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state     <= state_next;
      rvalid0_q <= beat && !op_we && !owner;
      rvalid1_q <= beat && !op_we && owner;
      if (beat && !op_we) begin
        if (owner) rdata1_q <= bus.m_r_data;
        else       rdata0_q <= bus.m_r_data;
      end
      if (accept) begin
        owner     <= winner;
        op_we     <= winner ? bus.we1   : bus.we0;
        cur_addr  <= winner ? bus.addr1 : bus.addr0;
        remaining <= winner ? bus.len1  : bus.len0;
      end else if (beat) begin
        // Byte address wraps naturally at 2^N.
        cur_addr  <= cur_addr + N'(4);
        remaining <= remaining - LEN_W'(1);
        if (last) rr_last <= owner;
      end
    end
  end

  assign bus.gnt0       = accept & ~winner;
  assign bus.gnt1       = accept & winner;
  assign bus.beat0      = beat & ~owner;
  assign bus.beat1      = beat & owner;
  assign bus.last0      = last & ~owner;
  assign bus.last1      = last & owner;
  assign bus.busy       = (state == BURST);
  assign bus.m_write_en = beat & op_we;
  assign bus.m_w_addr   = cur_addr;
  assign bus.m_r_addr   = cur_addr;
  assign bus.m_w_data   = (beat && op_we) ? (owner ? bus.wdata1 : bus.wdata0) : '0;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: directed scenarios plus random
// traffic compared against a transaction-level model and a shadow memory.
module tb_mem_burst_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_burst_arbiter_if #(.N(8), .B(8), .LEN_W(4)) bus ();

  mem_burst_arbiter #(.N(8), .B(8), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Byte-addressed big-endian memory driven by the DUT, and the bench's own image of it.
  logic [7:0]  mem    [256];
  logic [7:0]  shadow [256];
  logic        mem_clear;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_word;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (load_en) begin
      mem[load_addr]              <= load_word[31:24];
      mem[8'(load_addr + 8'd1)]   <= load_word[23:16];
      mem[8'(load_addr + 8'd2)]   <= load_word[15:8];
      mem[8'(load_addr + 8'd3)]   <= load_word[7:0];
    end else if (bus.m_write_en) begin
      mem[bus.m_w_addr]            <= bus.m_w_data[31:24];
      mem[8'(bus.m_w_addr + 8'd1)] <= bus.m_w_data[23:16];
      mem[8'(bus.m_w_addr + 8'd2)] <= bus.m_w_data[15:8];
      mem[8'(bus.m_w_addr + 8'd3)] <= bus.m_w_data[7:0];
    end
  end

  assign bus.m_r_data = {mem[bus.m_r_addr], mem[8'(bus.m_r_addr + 8'd1)],
                         mem[8'(bus.m_r_addr + 8'd2)], mem[8'(bus.m_r_addr + 8'd3)]};

  // Pending request of each requester and the last round-robin winner.
  bit         p_valid [2];
  bit         p_we    [2];
  logic [7:0] p_addr  [2];
  logic [3:0] p_len   [2];
  int         exp_rr_last;

  function automatic logic [31:0] shadow_word(input logic [7:0] a);
    return {shadow[a], shadow[8'(a + 8'd1)], shadow[8'(a + 8'd2)], shadow[8'(a + 8'd3)]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
  endfunction

  function automatic logic [7:0] ctl_vec();
    return {bus.gnt0, bus.gnt1, bus.beat0, bus.beat1, bus.last0, bus.last1, bus.busy, bus.m_write_en};
  endfunction

  function automatic logic [31:0] rdata_of(input int who);
    return (who == 0) ? bus.rdata0 : bus.rdata1;
  endfunction

  task automatic shadow_write(input logic [7:0] a, input logic [31:0] d);
    shadow[a]            = d[31:24];
    shadow[8'(a + 8'd1)] = d[23:16];
    shadow[8'(a + 8'd2)] = d[15:8];
    shadow[8'(a + 8'd3)] = d[7:0];
  endtask

  task automatic drive_req(input int who, input bit r);
    if (who == 0) begin
      bus.req0 = r; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.len0 = p_len[0];
    end else begin
      bus.req1 = r; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.len1 = p_len[1];
    end
  endtask

  task automatic drive_wdata(input int who, input logic [31:0] d);
    if (who == 0) bus.wdata0 = d;
    else          bus.wdata1 = d;
  endtask

  task automatic set_pending(input int who, input bit we, input logic [7:0] a, input logic [3:0] len);
    p_valid[who] = 1'b1; p_we[who] = we; p_addr[who] = a; p_len[who] = len;
  endtask

  task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
    load_addr = a; load_word = d; load_en = 1'b1;
    shadow_write(a, d);
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_req(0, 1'b0); drive_req(1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    exp_rr_last = 1;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
  endtask

  // One cycle with no requests: nothing may be granted, issued or returned.
  task automatic idle_cycle();
    drive_req(0, 1'b0); drive_req(1, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl_vec() !== 8'h00 || bus.m_w_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL idle_ctl: got ctl=%b wdata=%h expected ctl=00000000 wdata=0", ctl_vec(), bus.m_w_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_rvalid: got %b expected 00", {bus.rvalid0, bus.rvalid1});
    end
  endtask

  // Acceptance plus len+1 beats for requester 'who'. The other requester is
  // asserted from cycle late_at on (0 = acceptance cycle, k+1 = beat k, <0 = never)
  // and must see neither grant nor beat. The owner's inputs are scrambled during
  // the burst, which must have no effect.
  task automatic run_burst(input int who, input int late_at);
    int          other;
    bit          we;
    int          len;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [7:0]  exp_ctl;
    logic [1:0]  exp_rv;
    other  = 1 - who;
    we     = p_we[who];
    len    = int'(p_len[who]);
    a      = p_addr[who];
    exp_rd = '0;
    drive_req(who, 1'b1);
    drive_req(other, late_at == 0);
    @(negedge clk);
    exp_ctl = (who == 0) ? 8'h80 : 8'h40;
    checks++;
    if (ctl_vec() !== exp_ctl) begin
      errors++;
      $display("[TB] FAIL accept_ctl who=%0d: got %b expected %b", who, ctl_vec(), exp_ctl);
    end
    @(posedge clk); #1;
    for (int k = 0; k <= len; k++) begin
      p_we[who] = 1'($urandom); p_addr[who] = 8'($urandom); p_len[who] = 4'($urandom);
      drive_req(who, 1'($urandom));
      drive_req(other, late_at >= 0 && k + 1 >= late_at);
      d = $urandom;
      drive_wdata(who, d);
      drive_wdata(other, $urandom);
      @(negedge clk);
      exp_ctl = {2'b00, who == 0, who == 1, who == 0 && k == len, who == 1 && k == len, 1'b1, we};
      checks++;
      if (ctl_vec() !== exp_ctl) begin
        errors++;
        $display("[TB] FAIL beat_ctl who=%0d beat=%0d: got %b expected %b", who, k, ctl_vec(), exp_ctl);
      end
      checks++;
      if (bus.m_w_data !== (we ? d : 32'h0)) begin
        errors++;
        $display("[TB] FAIL beat_wdata who=%0d beat=%0d: got %h expected %h", who, k, bus.m_w_data, we ? d : 32'h0);
      end
      checks++;
      if ((we ? bus.m_w_addr : bus.m_r_addr) !== a) begin
        errors++;
        $display("[TB] FAIL beat_addr who=%0d beat=%0d: got %h expected %h", who, k,
                 we ? bus.m_w_addr : bus.m_r_addr, a);
      end
      if (we) shadow_write(a, d);
      else    exp_rd = shadow_word(a);
      @(posedge clk); #1;
      exp_rv = we ? 2'b00 : ((who == 0) ? 2'b10 : 2'b01);
      checks++;
      if ({bus.rvalid0, bus.rvalid1} !== exp_rv) begin
        errors++;
        $display("[TB] FAIL rvalid who=%0d beat=%0d: got %b expected %b", who, k, {bus.rvalid0, bus.rvalid1}, exp_rv);
      end
      if (!we) begin
        checks++;
        if (rdata_of(who) !== exp_rd) begin
          errors++;
          $display("[TB] FAIL rdata who=%0d beat=%0d: got %h expected %h", who, k, rdata_of(who), exp_rd);
        end
      end
      a = a + 8'd4;
    end
    exp_rr_last  = who;
    p_valid[who] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ctl_vec() !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got %b expected 00000000", ctl_vec());
    end
    checks++;
    if (bus.m_r_addr !== 8'h00 || bus.m_w_addr !== 8'h00 || bus.m_w_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_port: got raddr=%h waddr=%h wdata=%h expected 0", bus.m_r_addr, bus.m_w_addr, bus.m_w_data);
    end
    checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00 || bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_read: got rv=%b rd0=%h rd1=%h expected 0", {bus.rvalid0, bus.rvalid1}, bus.rdata0, bus.rdata1);
    end
  endtask

  task automatic test_single_write();
    set_pending(0, 1'b1, 8'h40, 4'd3);
    run_burst(0, -1);
    idle_cycle();
  endtask

  task automatic test_read_burst();
    mem_load(8'h00, 32'h04080005);
    mem_load(8'h04, 32'h04090001);
    set_pending(1, 1'b0, 8'h00, 4'd1);
    run_burst(1, -1);
    idle_cycle();
    checks++;
    if (bus.rdata1 !== 32'h04090001) begin
      errors++;
      $display("[TB] FAIL read_hold: got %h expected 04090001", bus.rdata1);
    end
  endtask

  task automatic test_contention();
    do_reset();
    set_pending(0, 1'b1, 8'h10, 4'd0);
    set_pending(1, 1'b1, 8'h20, 4'd0);
    run_burst(0, 0);
    run_burst(1, -1);
    set_pending(0, 1'b0, 8'h10, 4'd0);
    set_pending(1, 1'b0, 8'h20, 4'd0);
    run_burst(0, 0);
    run_burst(1, -1);
    idle_cycle();
  endtask

  task automatic test_wrap();
    set_pending(1, 1'b1, 8'hF8, 4'd2);
    run_burst(1, -1);
    idle_cycle();
    set_pending(0, 1'b0, 8'hF8, 4'd2);
    run_burst(0, -1);
    idle_cycle();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d;
    // A completed requester-0 burst first, so a lost rr_last reset would show.
    set_pending(0, 1'b1, 8'h10, 4'd0);
    run_burst(0, -1);
    idle_cycle();
    set_pending(0, 1'b1, 8'h80, 4'd3);
    shadow_write(8'h88, 32'h0);
    shadow_write(8'h8C, 32'h0);
    mem_load(8'h88, 32'h0);
    mem_load(8'h8C, 32'h0);
    drive_req(0, 1'b1); drive_req(1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_gnt: got %b expected 1", bus.gnt0);
    end
    @(posedge clk); #1;
    drive_req(0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      d = $urandom | 32'h1;
      drive_wdata(0, d);
      @(negedge clk);
      checks++;
      if (bus.m_write_en !== 1'b1 || bus.m_w_addr !== 8'(8'h80 + 4 * k)) begin
        errors++;
        $display("[TB] FAIL midrst_beat%0d: got we=%b addr=%h expected we=1 addr=%h", k, bus.m_write_en, bus.m_w_addr, 8'(8'h80 + 4 * k));
      end
      if (k < 2) begin
        shadow_write(8'(8'h80 + 4 * k), d);
        @(posedge clk); #1;
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ctl_vec() !== 8'h00 || bus.m_w_data !== 32'h0 || bus.m_r_addr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_async: got ctl=%b wdata=%h raddr=%h expected 0", ctl_vec(), bus.m_w_data, bus.m_r_addr);
    end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    exp_rr_last = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_word(8'(8'h80 + 4 * k)) !== shadow_word(8'(8'h80 + 4 * k))) begin
        errors++;
        $display("[TB] FAIL midrst_mem%0d: got %h expected %h", k, mem_word(8'(8'h80 + 4 * k)), shadow_word(8'(8'h80 + 4 * k)));
      end
    end
    set_pending(0, 1'b0, 8'h30, 4'd0);
    set_pending(1, 1'b0, 8'h34, 4'd0);
    run_burst(0, 0);
    run_burst(1, -1);
    idle_cycle();
  endtask

  task automatic test_late_request();
    set_pending(0, 1'b1, 8'h20, 4'd3);
    set_pending(1, 1'b0, 8'h40, 4'd1);
    run_burst(0, 2);
    run_burst(1, -1);
    idle_cycle();
  endtask

  task automatic test_random();
    int win;
    int other;
    int late;
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_valid[r] && $urandom_range(0, 2) != 0)
          set_pending(r, 1'($urandom), 8'($urandom), 4'($urandom));
      end
      if (!p_valid[0] && !p_valid[1]) begin
        idle_cycle();
      end else begin
        win   = (p_valid[0] && p_valid[1]) ? 1 - exp_rr_last : (p_valid[1] ? 1 : 0);
        other = 1 - win;
        late  = p_valid[other] ? 0 : -1;
        if (!p_valid[other] && $urandom_range(0, 1) == 1) begin
          late = int'($urandom_range(1, int'(p_len[win]) + 1));
          set_pending(other, 1'($urandom), 8'($urandom), 4'($urandom));
        end
        run_burst(win, late);
      end
    end
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    idle_cycle();
  endtask

  task automatic test_memory_image();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (mem[i] !== shadow[i]) begin
        errors++;
        $display("[TB] FAIL mem_image[%02h]: got %h expected %h", i, mem[i], shadow[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_clear = 1'b1; load_en = 1'b0; load_addr = '0; load_word = '0;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    for (int r = 0; r < 2; r++) begin
      p_valid[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = '0; p_len[r] = '0;
    end
    drive_req(0, 1'b0); drive_req(1, 1'b0);
    drive_wdata(0, 32'h0); drive_wdata(1, 32'h0);
    exp_rr_last = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); mem_clear = 1'b0;
    test_reset();
    test_single_write();
    test_read_burst();
    test_contention();
    test_wrap();
    test_reset_mid_burst();
    test_late_request();
    test_random();
    test_memory_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Two-requester burst arbiter and sequencer for the shared byte-addressed, big-endian 32-bit-word data memory.
- Owns the memory write port (w_addr, w_data, write_en) and read port 2 (r_addr2, r_data2); read port 1 stays with instruction fetch and is not arbitrated.
- Arbitrates round-robin, then sequences a word burst of up to 2^LEN_W beats, advancing the byte address by 4 each beat.

Parameters:
- N, 8, byte-address width; must match the memory's address width.
- B, 8, byte width; word data width is 4*B.
- LEN_W, 4, burst length field width; a burst is len+1 beats.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  burst request; hold with we/addr/len stable until gnt.
- we0, we1  in  1 each  1 = write burst, 0 = read burst.
- addr0, addr1  in  N each  start byte address.
- len0, len1  in  LEN_W each  beats minus one.
- wdata0, wdata1  in  4*B each  current write beat data; advance after each beat pulse.
- gnt0, gnt1  out  1 each  one-cycle pulse when the burst is accepted.
- beat0, beat1  out  1 each  a beat is issued to memory this cycle.
- last0, last1  out  1 each  the issued beat is the final beat; qualified by beat.
- rvalid0, rvalid1  out  1 each  registered read data valid, one cycle after a read beat.
- rdata0, rdata1  out  4*B each  registered read data.
- m_r_addr  out  N  to memory r_addr2.
- m_r_data  in  4*B  from memory r_data2; combinational read.
- m_w_addr  out  N  to memory w_addr.
- m_w_data  out  4*B  to memory w_data.
- m_write_en  out  1  to memory write_en.
- busy  out  1  high in BURST.

Behaviour:
- State machine: IDLE and BURST.
- Registers: state, owner, op_we, cur_addr, remaining, rr_last, rdata0/1, rvalid0/1.
- Reset values:
  - state = IDLE, cur_addr = 0, remaining = 0, owner = 0, rr_last = 1.
  - rvalid* = 0, rdata* = 0.
  - Combinational outputs follow the reset state: gnt*/beat*/last*/m_write_en/busy = 0.
  - m_r_addr = m_w_addr = cur_addr = 0; m_w_data = 0 whenever not writing.
- IDLE with any request: acceptance cycle.
  - Winner is the single requester if only one requests.
  - If both request, the winner is the requester other than rr_last; after reset, requester 0 wins first.
  - gnt_winner pulses combinationally in the acceptance cycle.
  - At the edge: owner, op_we <= we, cur_addr <= addr, remaining <= len, state <= BURST.
- BURST: exactly one beat per cycle.
  - beat_owner = 1; last_owner = (remaining == 0).
  - Write beat: m_write_en = 1, m_w_addr = cur_addr, m_w_data = wdata_owner; memory captures the word at the same edge.
  - Read beat: m_r_addr = cur_addr; at the edge rdata_owner <= m_r_data and rvalid_owner <= 1.
  - rvalid is 0 on any cycle not following a read beat; rdata holds its value when rvalid = 0.
  - Each beat: cur_addr <= cur_addr + 4 modulo 2^N (wraps, e.g. 8'hFC -> 8'h00).
  - Each beat: remaining <= remaining - 1.
  - On the last beat: state <= IDLE, rr_last <= owner.
- Timing:
  - A burst of L+1 beats occupies L+2 cycles (acceptance plus beats).
  - Bursts are never back-to-back; at least one IDLE cycle separates them.
  - Read latency is one cycle from beat to rvalid.
- No abort: req changes during BURST are ignored and the burst runs to completion.
- The non-owner's request stays pending with gnt = 0 and is evaluated at the next IDLE cycle.
- A request arriving during BURST never preempts the current burst.
- Unaligned start addresses are legal and passed through unmodified.
- Reset mid-burst takes effect immediately (asynchronous): m_write_en drops without waiting for a clock, the burst is abandoned, and no further beats are issued.
- No outputs are driven to X; all outputs are defined in every state.

Test Plan:
- Single write: req0, we0 = 1, addr0 = 8'h40, len0 = 3, wdata advancing per beat A0..A3 -> gnt0 at cycle 0; m_write_en on cycles 1-4 at addresses 40, 44, 48, 4C; last0 on cycle 4; busy low on cycle 5.
- Read burst: req1, we1 = 0, addr1 = 8'h00, len1 = 1, memory preloaded 04080005 / 04090001 -> rvalid1 on cycles 2-3 with those words in order; rvalid0 stays 0.
- Contention: req0 and req1 both asserted from reset, len = 0 each -> gnt0 first, then gnt1 after one IDLE cycle; repeat both -> gnt0 again.
- Wrap: write burst addr = 8'hF8, len = 2 -> beats at F8, FC, 00.
- Reset mid-burst: assert rst during beat 2 of a 4-beat write -> m_write_en falls before the next edge; only beats 0-1 are written; state IDLE, rr_last = 1.
- Late request: req1 asserted during requester 0's burst -> gnt1 only in the first IDLE cycle after last0; no beat1 during requester 0's burst.
